// File: rtl/timer_multi.sv
// timer_multi: memory-mapped 64-bit machine timer with prescaler and NumCmp compare channels.
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   timer_req_i               one-cycle bus request (window decoded externally)
//   timer_addr_i              byte address, only [9:0] decoded
//   timer_we_i / timer_be_i   write flag and byte enables
//   timer_wdata_i             write data
//   timer_rvalid_o            response valid one cycle after each request
//   timer_rdata_o             read data, 0 on writes and errors
//   timer_err_o               access error, qualified by rvalid
//   timer_intr_o              OR of enabled pending channel interrupts
//   timer_chan_intr_o         per-channel enabled pending interrupts
module timer_multi #(
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int NumCmp        = 4,
    parameter int PrescaleWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    timer_req_i,
    input  logic [AddressWidth-1:0] timer_addr_i,
    input  logic                    timer_we_i,
    input  logic [DataWidth/8-1:0]  timer_be_i,
    input  logic [DataWidth-1:0]    timer_wdata_i,
    output logic                    timer_rvalid_o,
    output logic [DataWidth-1:0]    timer_rdata_o,
    output logic                    timer_err_o,
    output logic                    timer_intr_o,
    output logic [NumCmp-1:0]       timer_chan_intr_o
);
    if (DataWidth != 32) begin : g_bad_data_width
        $error("timer_multi: DataWidth must be 32");
    end
    if (NumCmp < 1 || NumCmp > 8) begin : g_bad_num_cmp
        $error("timer_multi: NumCmp must be 1..8");
    end
    if (PrescaleWidth < 1 || PrescaleWidth > 32) begin : g_bad_prescale_width
        $error("timer_multi: PrescaleWidth must be 1..32");
    end

    function automatic logic [31:0] merge(input logic [31:0] q, input logic [31:0] d, input logic [31:0] m);
        return (q & ~m) | (d & m);
    endfunction

    logic [63:0]              r_mtime;
    logic                     r_enable;
    logic [PrescaleWidth-1:0] r_prescale;
    logic [PrescaleWidth-1:0] r_pcnt;
    logic [NumCmp-1:0]        r_intr_state;
    logic [NumCmp-1:0]        r_intr_enable;
    logic [63:0]              r_cmp [NumCmp];
    logic [31:0]              r_period [NumCmp];
    logic [NumCmp-1:0]        r_periodic;
    logic                     r_rvalid;
    logic [31:0]              r_rdata;
    logic                     r_err;

    logic [9:0]               w_addr;
    logic                     w_addr_unused;
    logic [2:0]               w_sel;
    logic [31:0]              w_bm;
    logic                     w_glb;
    logic                     w_chn;
    logic                     w_valid;
    logic                     w_wr;
    logic [5:0]               w_wr_glb;
    logic [NumCmp-1:0]        w_hit;
    logic [NumCmp-1:0]        w_match;
    logic [NumCmp-1:0]        w_cmp_wr;
    logic [NumCmp-1:0]        w_w1c;
    logic [NumCmp-1:0]        w_state_d;
    logic [31:0]              w_glb_rd;
    logic [31:0]              w_chn_rd;
    logic                     w_tick;
    logic [63:0]              w_mtime_base;
    logic [63:0]              w_mtime_d;
    logic [PrescaleWidth-1:0] w_pcnt_d;

    assign w_addr        = timer_addr_i[9:0];
    assign w_addr_unused = ^timer_addr_i[AddressWidth-1:10];
    assign w_sel         = w_addr[4:2];
    assign w_bm          = {{8{timer_be_i[3]}}, {8{timer_be_i[2]}}, {8{timer_be_i[1]}}, {8{timer_be_i[0]}}};
    assign w_glb         = (w_addr[9:5] == 5'd0) && (w_addr[1:0] == 2'd0) && (w_sel <= 3'd5);
    assign w_chn         = (|w_hit) && (w_addr[1:0] == 2'd0);
    assign w_valid       = w_glb | w_chn;
    assign w_wr          = timer_req_i & timer_we_i & w_valid;

    always_comb begin
        w_chn_rd = '0;
        for (int n = 0; n < NumCmp; n++) begin
            w_hit[n]   = (w_addr[9:8] == 2'b01) && (w_addr[7:4] == 4'(n));
            w_match[n] = r_mtime >= r_cmp[n];
            if (w_hit[n])
                w_chn_rd = w_addr[3:2] == 2'd0 ? r_cmp[n][31:0] :
                           w_addr[3:2] == 2'd1 ? r_cmp[n][63:32] :
                           w_addr[3:2] == 2'd2 ? {31'd0, r_periodic[n]} : r_period[n];
        end
    end

    always_comb begin
        w_wr_glb = '0;
        w_cmp_wr = '0;
        for (int k = 0; k < 6; k++) w_wr_glb[k] = w_wr & w_glb & (w_sel == 3'(k));
        for (int n = 0; n < NumCmp; n++) w_cmp_wr[n] = w_wr & w_hit[n] & ~w_addr[3];
    end

    assign w_glb_rd = w_sel == 3'd0 ? r_mtime[31:0] :
                      w_sel == 3'd1 ? r_mtime[63:32] :
                      w_sel == 3'd2 ? {31'd0, r_enable} :
                      w_sel == 3'd3 ? 32'(r_prescale) :
                      w_sel == 3'd4 ? 32'(r_intr_state) : 32'(r_intr_enable);

    assign w_tick       = r_enable & (r_pcnt == r_prescale);
    assign w_mtime_base = w_tick ? r_mtime + 64'd1 : r_mtime;
    // The written half takes the bus value untouched; the other half still advances, carry included.
    assign w_mtime_d    = w_wr_glb[0] ? {w_mtime_base[63:32], merge(r_mtime[31:0], timer_wdata_i, w_bm)} :
                          w_wr_glb[1] ? {merge(r_mtime[63:32], timer_wdata_i, w_bm), w_mtime_base[31:0]} :
                          w_mtime_base;
    // A lowered limit can strand pcnt above it; restart from 0 without ticking.
    assign w_pcnt_d     = w_wr_glb[3] ? '0 :
                          !r_enable ? r_pcnt :
                          (w_tick || r_pcnt > r_prescale) ? '0 : r_pcnt + PrescaleWidth'(1);
    assign w_w1c        = w_wr_glb[4] ? NumCmp'(timer_wdata_i & w_bm) : '0;
    // Match wins over W1C, but a CMP write both clears and masks that cycle's match.
    assign w_state_d    = ((r_intr_state & ~w_w1c) | w_match) & ~w_cmp_wr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mtime       <= '0;
            r_enable      <= 1'b1;
            r_prescale    <= '0;
            r_pcnt        <= '0;
            r_intr_state  <= '0;
            r_intr_enable <= '0;
            r_periodic    <= '0;
            r_rvalid      <= 1'b0;
            r_rdata       <= '0;
            r_err         <= 1'b0;
            for (int n = 0; n < NumCmp; n++) begin
                r_cmp[n]    <= '1;
                r_period[n] <= '0;
            end
        end else begin
            r_rvalid     <= timer_req_i;
            if (timer_req_i) begin
                r_rdata <= (timer_we_i || !w_valid) ? '0 : (w_glb ? w_glb_rd : w_chn_rd);
                r_err   <= ~w_valid;
            end
            r_mtime      <= w_mtime_d;
            r_pcnt       <= w_pcnt_d;
            r_intr_state <= w_state_d;
            if (w_wr_glb[2] && timer_be_i[0]) r_enable <= timer_wdata_i[0];
            if (w_wr_glb[3]) r_prescale <= PrescaleWidth'(merge(32'(r_prescale), timer_wdata_i, w_bm));
            if (w_wr_glb[5]) r_intr_enable <= NumCmp'(merge(32'(r_intr_enable), timer_wdata_i, w_bm));
            for (int n = 0; n < NumCmp; n++) begin
                // A bus write to CMP takes priority over a same-cycle periodic reload.
                if (w_cmp_wr[n])
                    r_cmp[n] <= w_addr[2] ? {merge(r_cmp[n][63:32], timer_wdata_i, w_bm), r_cmp[n][31:0]}
                                          : {r_cmp[n][63:32], merge(r_cmp[n][31:0], timer_wdata_i, w_bm)};
                else if (r_periodic[n] && w_match[n])
                    r_cmp[n] <= r_cmp[n] + {32'd0, r_period[n]};
                if (w_wr && w_hit[n] && w_addr[3:2] == 2'd2 && timer_be_i[0]) r_periodic[n] <= timer_wdata_i[0];
                if (w_wr && w_hit[n] && w_addr[3:2] == 2'd3) r_period[n] <= merge(r_period[n], timer_wdata_i, w_bm);
            end
        end
    end

    assign timer_rvalid_o    = r_rvalid;
    assign timer_rdata_o     = r_rdata;
    assign timer_err_o       = r_err;
    assign timer_chan_intr_o = r_intr_state & r_intr_enable;
    assign timer_intr_o      = |timer_chan_intr_o;
endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
- Memory-mapped 64-bit machine timer with a programmable prescaler and NumCmp independent 64-bit compare channels.
- Each channel can run one-shot or periodic (auto-reload by adding a period).
- Per-channel interrupt state, enable and W1C clear, with aggregated and per-channel interrupt outputs.
- Sits on the shared 1 kB peripheral bus window; upper address bits are decoded externally into timer_req_i.

Parameters:
- DataWidth, 32, bus data width; must be 32 (init assertion).
- AddressWidth, 32, bus address width; only addr[9:0] is decoded.
- NumCmp, 4, number of compare channels, 1..8 (init assertion).
- PrescaleWidth, 16, width of the prescaler count/limit, 1..32.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- timer_req_i  input  1  bus request, one cycle per access.
- timer_addr_i  input  AddressWidth  byte address; bits [9:0] decoded.
- timer_we_i  input  1  1 = write, 0 = read.
- timer_be_i  input  DataWidth/8  byte enables, writes only.
- timer_wdata_i  input  DataWidth  write data.
- timer_rvalid_o  output  1  response valid, exactly 1 cycle after each request.
- timer_rdata_o  output  DataWidth  read data; 0 on writes and errors.
- timer_err_o  output  1  access error, qualified by rvalid.
- timer_intr_o  output  1  |(intr_state & intr_enable).
- timer_chan_intr_o  output  NumCmp  intr_state & intr_enable, per channel.

Behaviour:
- Register map, addr[9:0]:
  - 0x000 MTIME_LO, 0x004 MTIME_HI.
  - 0x008 CTRL: bit0 = count enable; other bits read 0.
  - 0x00C PRESCALE: [PrescaleWidth-1:0].
  - 0x010 INTR_STATE: W1C.
  - 0x014 INTR_ENABLE.
  - Channel n at 0x100 + 16*n: +0 CMP_LO, +4 CMP_HI, +8 CFG (bit0 = periodic), +C PERIOD (32-bit).
- Errors:
  - Any other offset, including channel n >= NumCmp → err = 1, rdata = 0, write has no effect.
  - Reads and writes to valid offsets → err = 0.
- Byte enables:
  - Unwritten bytes keep the current register value.
  - W1C applies only to bits in enabled bytes.
- Reset values:
  - mtime 0; CTRL.enable 1; PRESCALE 0.
  - INTR_STATE 0; INTR_ENABLE 0.
  - CMP all-ones; CFG 0; PERIOD 0.
  - Outputs: rvalid 0, rdata 0, err 0, intr 0.
- Response:
  - rvalid_q <= req_i.
  - rdata_q / err_q are captured only when req_i is high; they hold otherwise.
  - Reset mid-access drops the response: rvalid stays 0 after reset release.
- Prescaler:
  - pcnt counts 0..PRESCALE while CTRL.enable = 1.
  - tick = enable & (pcnt == PRESCALE); pcnt returns to 0 on tick.
  - PRESCALE = 0 → tick every cycle.
  - enable = 0 → pcnt and mtime hold.
  - A PRESCALE write resets pcnt to 0.
  - If pcnt > PRESCALE (limit lowered), the next cycle resets pcnt to 0 with no tick.
- mtime:
  - Increments by 1 on tick, full 64-bit add.
  - Wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
- MTIME write in a tick cycle:
  - The written half = byte merge of wdata with mtime_q, no increment.
  - The other half takes the incremented value, carry included.
- Match and interrupt:
  - match[n] = (mtime_q >= cmp_q[n]), unsigned 64-bit, evaluated every cycle.
  - match[n] sets intr_state[n] next cycle; the bit is sticky.
- One-shot mode (CFG.periodic = 0): cmp is unchanged on match.
- Periodic mode (CFG.periodic = 1):
  - On match[n], cmp_q[n] <= cmp_q[n] + zero-extended PERIOD (64-bit, wraps).
  - Reloads again each cycle while match persists; each reload sets intr_state[n].
  - PERIOD = 0 → behaves as one-shot.
- Clearing intr_state[n]:
  - W1C to INTR_STATE, or any write to CMP_LO/CMP_HI of channel n.
  - Set beats clear in the same cycle, except a CMP write: the CMP write clears the bit and suppresses that cycle's set.
  - A bus write to CMP in the same cycle as a periodic reload: the bus write wins; the reload is dropped.
- Interrupt outputs are registered-state based: they assert 1 cycle after match (combinational from intr_state_q and intr_enable_q).

Test Plan:
- Reset, read 0x000/0x100/0x008 → rdata 0, 0xFFFF_FFFF, 1; err 0; rvalid exactly 1 cycle after each req; intr_o 0.
- PRESCALE = 3, enable: after 40 cycles MTIME_LO = 10 (±1); CTRL = 0 freezes the value across 20 cycles.
- MTIME = 0xFFFF_FFFF_FFFF_FFFE, PRESCALE 0: after 2 ticks reads 0 in both halves; after 3 ticks LO = 1, HI = 0.
- Ch1 CMP = 50, periodic = 1, PERIOD = 20, INTR_ENABLE = 0x2:
  - intr_o rises 1 cycle after mtime reaches 50.
  - CMP reads 70; W1C 0x2 clears intr_o.
  - intr_o re-asserts at mtime 70.
- Ch0 one-shot CMP = 10: intr_state[0] set and held; writing CMP_LO = 100 clears it; it stays clear until mtime ≥ 100.
- Access 0x130 with NumCmp = 3, and 0x018 → err 1, rdata 0, no register changes; byte write be = 0x2 to PERIOD changes only bits [15:8].
